// File: rtl/tri_bank_loader.sv
// rtl/tri_bank_loader.sv - double-buffered triangle-table loader for the scan stage
module tri_bank_loader #(
    parameter int DATA_W     = 216,
    parameter int ADDR_W     = 12,
    parameter int BANK_DEPTH = 2048,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              swap,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] wsize,
    output logic              bank,
    output logic              pending,
    output logic              ovf,
    output logic [CNT_W-1:0]  commits
);

    typedef enum logic [1:0] {INIT, LOAD, PEND} state_t;

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(BANK_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] count;
    logic              accept;
    logic              do_write;
    logic              commit;
    logic              full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = LOAD;
            LOAD:    if (accept && s_last) state_nxt = PEND;
            PEND:    if (swap) state_nxt = LOAD;
            default: state_nxt = INIT;
        endcase
    end

    // swap only matters once the scene is sealed; earlier pulses are ignored
    always_comb begin
        full     = (count == DEPTH);
        accept   = s_valid && s_ready;
        do_write = accept && !full;
        commit   = (state == PEND) && swap;
        pending  = (state == PEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ready <= 1'b0;
            wen     <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            wsize   <= '0;
            bank    <= 1'b0;
            ovf     <= 1'b0;
            commits <= '0;
            count   <= '0;
        end else begin
            s_ready <= (state_nxt == LOAD);
            wen     <= do_write;
            if (do_write) begin
                waddr <= {~bank, count[ADDR_W-2:0]};
                wdata <= s_data;
            end
            if (accept && full) begin
                ovf <= 1'b1;
            end
            // a commit can never coincide with a write: s_ready is low in PEND
            if (commit) begin
                bank    <= ~bank;
                wsize   <= count;
                count   <= '0;
                commits <= commits + CNT_W'(1);
            end else if (do_write) begin
                count <= count + ADDR_W'(1);
            end
        end
    end

endmodule
